seq_adder: RTL

Parametrised multi-cycle adder/subtractor, successor to the 16-bit combinational `adder`. It processes operands CHUNK bits per clock, least significant chunk first, with a registered ripple carry between chunks. A start/busy/done handshake lets a controller launch an operation and collect a held result. It sits between the operand registers and any datapath unit that can tolerate multi-cycle latency in exchange for a narrow adder.

---
 rtl/seq_adder_pkg.sv | 17 +
 rtl/seq_adder_chunk_adder.sv | 21 ++
 rtl/seq_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
package seq_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bits needed to count n steps; never less than 1 so a counter always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_adder_chunk_adder.sv
// One CHUNK-wide slice of the ripple adder, with the carry into its MSB exposed.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign s    = sum[CHUNK-1:0];
  assign co   = sum[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out of the sum.
  assign cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LS chunk first, registered ripple carry.
// Handshake: start_i is taken only while busy_o is low; done_o pulses for one cycle once result_o/carry_o/overflow_o are valid.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             state_o
);
  import seq_adder_pkg::*;

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic            carry_r;
  logic            capture, last;
  logic [CHUNK-1:0] s;
  logic            co, cmsb;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .ci   (carry_r),
    .s    (s),
    .co   (co),
    .cmsb (cmsb)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          capture   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        last = (cnt == LAST);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      carry_r    <= 1'b0;
      result_o   <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= last;
      if (capture) begin
        // B is inverted once at capture; the +1 of subtraction enters as the initial carry.
        a_sh       <= a_i;
        b_sh       <= b_i ^ {WIDTH{sub_i}};
        carry_r    <= sub_i;
        cnt        <= '0;
        result_o   <= '0;
        carry_o    <= 1'b0;
        overflow_o <= 1'b0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> CHUNK;
        b_sh    <= b_sh >> CHUNK;
        carry_r <= co;
        cnt     <= last ? '0 : cnt + CW'(1);
        for (int k = 0; k < N; k++) begin
          if (cnt == CW'(k)) result_o[k*CHUNK +: CHUNK] <= s;
        end
        if (last) begin
          carry_o    <= co;
          overflow_o <= co ^ cmsb;
        end
      end
    end
  end

  assign busy_o  = (state == RUN);
  assign state_o = state;

endmodule
